// File: rtl/bs_mc_sequencer_if.sv
// Host/datapath bundle for the Black-Scholes Monte-Carlo sequencer.
// The master side is the host plus RNG and conversion stage; the slave side is the sequencer.
interface bs_mc_sequencer_if #(
  parameter int CNT_W = 20,
  parameter int FX_W  = 64,
  parameter int ACC_W = 72
);
  logic [3:0]       cmd;
  logic [CNT_W-1:0] num_paths;
  logic             rng_valid;
  logic             issue;
  logic [FX_W-1:0]  res_din;
  logic [3:0]       status;
  logic [ACC_W-1:0] acc_out;
  logic [CNT_W-1:0] done_cnt;
  logic             overflow;

  modport master (
    output cmd, num_paths, rng_valid, res_din,
    input  issue, status, acc_out, done_cnt, overflow
  );

  modport slave (
    input  cmd, num_paths, rng_valid, res_din,
    output issue, status, acc_out, done_cnt, overflow
  );
endinterface

// File: rtl/bs_mc_sequencer.sv
// Monte-Carlo path sequencer: issues samples into a fixed-latency datapath, tags them and sums the tagged results.
// Optional macro BS_SEQ_SAT_EN: saturating accumulator with sticky overflow; otherwise the sum wraps.
module bs_mc_sequencer #(
  parameter int         CNT_W     = 20,
  parameter int         PIPE_LAT  = 46,
  parameter int         FX_W      = 64,
  parameter int         ACC_W     = 72,
  parameter logic [3:0] CMD_RUN   = 4'd1,
  parameter logic [3:0] CMD_ACK   = 4'd2,
  parameter logic [3:0] CMD_ABORT = 4'd3
) (
  input logic               clk,
  input logic               nreset,
  bs_mc_sequencer_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]          state;
  logic [CNT_W-1:0]    target;
  logic [CNT_W-1:0]    issued;
  logic [CNT_W-1:0]    done_q;
  logic [ACC_W-1:0]    acc;
  logic                ovf;
  logic [PIPE_LAT-1:0] tag_line;

  logic                issue_w;
  logic                tag_out;
  logic                clear_run;
  logic [ACC_W:0]      add_res;

  // Result bit ACC_W is the overflow event for this add; always 0 when wrapping.
`ifdef BS_SEQ_SAT_EN
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a, input logic [FX_W-1:0] d);
    logic [ACC_W:0] sum;
    sum = {1'b0, a} + (ACC_W+1)'(d);
    if (sum[ACC_W]) acc_add = {1'b1, {ACC_W{1'b1}}};
    else            acc_add = sum;
  endfunction
`else
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a, input logic [FX_W-1:0] d);
    acc_add = {1'b0, a + ACC_W'(d)};
  endfunction
`endif

  assign issue_w   = (state == ST_RUN) && bus.rng_valid && (issued < target);
  assign tag_out   = tag_line[PIPE_LAT-1];
  assign add_res   = acc_add(acc, bus.res_din);
  assign clear_run = (((state == ST_RUN) || (state == ST_DRAIN)) && (bus.cmd == CMD_ABORT)) ||
                     ((state == ST_DONE) && (bus.cmd == CMD_ACK));

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state    <= ST_IDLE;
      target   <= '0;
      issued   <= '0;
      done_q   <= '0;
      acc      <= '0;
      ovf      <= 1'b0;
      tag_line <= '0;
    end else if (clear_run) begin
      // Abort and acknowledge both drop in-flight tags so stale results never reach the next run.
      state    <= ST_IDLE;
      target   <= '0;
      issued   <= '0;
      done_q   <= '0;
      acc      <= '0;
      ovf      <= 1'b0;
      tag_line <= '0;
    end else begin
      tag_line <= PIPE_LAT'({tag_line, issue_w});
      if (issue_w) issued <= issued + CNT_W'(1);
      if (tag_out) begin
        acc    <= add_res[ACC_W-1:0];
        ovf    <= ovf | add_res[ACC_W];
        done_q <= done_q + CNT_W'(1);
      end
      case (state)
        ST_IDLE: begin
          if (bus.cmd == CMD_RUN) begin
            target <= bus.num_paths;
            state  <= (bus.num_paths == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (issue_w && ((issued + CNT_W'(1)) == target)) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (done_q == target) state <= ST_DONE;
        end
        default: ;
      endcase
    end
  end

  assign bus.issue    = issue_w;
  assign bus.status   = {2'b00, state};
  assign bus.acc_out  = acc;
  assign bus.done_cnt = done_q;
  assign bus.overflow = ovf;

endmodule

// File: tb/tb_bs_mc_sequencer.sv
// Bench for bs_mc_sequencer: a queue of due accumulate edges models the tag line; tasks check each scenario.
module tb_bs_mc_sequencer;
  localparam int CNT_W    = 8;
  localparam int PIPE_LAT = 4;
  localparam int FX_W     = 16;
  localparam int ACC_W    = 24;

  localparam logic [3:0] C_NOP = 4'd0, C_RUN = 4'd1, C_ACK = 4'd2, C_ABORT = 4'd3;
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3;

`ifdef BS_SEQ_SAT_EN
  localparam logic [7:0] SAT_ACC = 8'd255;
  localparam logic       SAT_OVF = 1'b1;
`else
  localparam logic [7:0] SAT_ACC = 8'd144;
  localparam logic       SAT_OVF = 1'b0;
`endif

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  bs_mc_sequencer_if #(.CNT_W(CNT_W), .FX_W(FX_W), .ACC_W(ACC_W)) bus ();
  bs_mc_sequencer_if #(.CNT_W(CNT_W), .FX_W(8), .ACC_W(8)) sbus ();

  bs_mc_sequencer #(.CNT_W(CNT_W), .PIPE_LAT(PIPE_LAT), .FX_W(FX_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .nreset(nreset), .bus(bus.slave));

  bs_mc_sequencer #(.CNT_W(CNT_W), .PIPE_LAT(PIPE_LAT), .FX_W(8), .ACC_W(8)) sdut (
    .clk(clk), .nreset(nreset), .bus(sbus.slave));

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [1:0]       m_st;
  int               m_issued, m_target, m_done, m_issues;
  logic [ACC_W-1:0] m_acc;
  int               due_q[$];
  int               cyc = 0;
  int               dut_issues;

  task automatic model_clear();
    m_acc = '0; m_done = 0; m_issued = 0; m_target = 0;
    due_q.delete();
  endtask

  // One clock cycle: drive at negedge, advance the model across the posedge, return at next negedge.
  task automatic drive(input logic [3:0] c, input logic rv, input logic [FX_W-1:0] rd, input logic [CNT_W-1:0] np);
    logic       m_issue, acc_due;
    logic [1:0] nst;
    int         done_before;
    bus.cmd = c; bus.rng_valid = rv; bus.res_din = rd; bus.num_paths = np;
    #1;
    if (bus.issue === 1'b1) dut_issues++;
    m_issue     = (m_st == S_RUN) && rv && (m_issued < m_target);
    acc_due     = (due_q.size() > 0) && (due_q[0] == cyc + 1);
    done_before = m_done;
    nst         = m_st;
    case (m_st)
      S_IDLE: if (c == C_RUN) begin
        m_target = int'(np);
        nst = (np == 0) ? S_DONE : S_RUN;
      end
      S_RUN, S_DRAIN: begin
        if (c == C_ABORT) begin
          model_clear();
          nst = S_IDLE;
        end else begin
          if (m_st == S_DRAIN && done_before == m_target) nst = S_DONE;
          if (m_issue) begin
            m_issues++;
            m_issued++;
            due_q.push_back(cyc + 1 + PIPE_LAT);
            if (m_issued == m_target) nst = S_DRAIN;
          end
          if (acc_due) begin
            void'(due_q.pop_front());
            m_acc = m_acc + ACC_W'(rd);
            m_done++;
          end
        end
      end
      default: if (c == C_ACK) begin
        model_clear();
        nst = S_IDLE;
      end
    endcase
    @(posedge clk);
    cyc++;
    m_st = nst;
    @(negedge clk);
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    bus.cmd = C_NOP; bus.rng_valid = 1'b1; bus.res_din = '0; bus.num_paths = '0;
    sbus.cmd = C_NOP; sbus.rng_valid = 1'b0; sbus.res_din = '0; sbus.num_paths = '0;
    m_st = S_IDLE; model_clear(); m_issues = 0; dut_issues = 0;
    #2;
    checks++; if (bus.status !== 4'd0) begin errors++; $display("FAIL reset_status got=%0d exp=0", bus.status); end
    checks++; if (bus.issue !== 1'b0) begin errors++; $display("FAIL reset_issue got=%b exp=0", bus.issue); end
    checks++; if (bus.acc_out !== '0) begin errors++; $display("FAIL reset_acc got=%0d exp=0", bus.acc_out); end
    checks++; if (bus.done_cnt !== '0) begin errors++; $display("FAIL reset_done got=%0d exp=0", bus.done_cnt); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", bus.overflow); end
    @(negedge clk);
    nreset = 1'b1;
    bus.rng_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_run();
    dut_issues = 0;
    drive(C_RUN, 1'b1, 16'd5, 8'd3);
    for (int i = 0; i < 7; i++) drive(C_NOP, 1'b1, 16'd5, 8'd0);
    checks++; if (bus.status !== 4'd2) begin errors++; $display("FAIL basic_pre_complete got=%0d exp=2", bus.status); end
    drive(C_NOP, 1'b1, 16'd5, 8'd0);
    checks++; if (bus.status !== 4'd3) begin errors++; $display("FAIL basic_status got=%0d exp=3", bus.status); end
    checks++; if (bus.acc_out !== 24'd15) begin errors++; $display("FAIL basic_acc got=%0d exp=15", bus.acc_out); end
    checks++; if (bus.done_cnt !== 8'd3) begin errors++; $display("FAIL basic_done got=%0d exp=3", bus.done_cnt); end
    checks++; if (dut_issues !== 3) begin errors++; $display("FAIL basic_issues got=%0d exp=3", dut_issues); end
    drive(C_ACK, 1'b0, 16'd0, 8'd0);
    checks++; if (bus.status !== 4'd0 || bus.acc_out !== '0 || bus.done_cnt !== '0)
      begin errors++; $display("FAIL basic_ack status=%0d acc=%0d done=%0d exp=0/0/0", bus.status, bus.acc_out, bus.done_cnt); end
  endtask

  task automatic test_bubbles();
    logic [6:0]      pat;
    logic [FX_W-1:0] rd;
    pat = 7'b1011001;  // applied LSB first: 1,0,0,1,1,0,1
    dut_issues = 0;
    drive(C_RUN, 1'b0, 16'hFFFF, 8'd4);
    for (int k = 0; k < 40 && bus.status !== 4'd3; k++) begin
      rd = ((due_q.size() > 0) && (due_q[0] == cyc + 1)) ? 16'd7 : 16'hFFFF;
      drive(C_NOP, (k < 7) ? pat[k] : 1'b0, rd, 8'd0);
    end
    checks++; if (bus.status !== 4'd3) begin errors++; $display("FAIL bubbles_complete got=%0d exp=3", bus.status); end
    checks++; if (bus.acc_out !== 24'd28) begin errors++; $display("FAIL bubbles_acc got=%0d exp=28", bus.acc_out); end
    checks++; if (bus.done_cnt !== 8'd4) begin errors++; $display("FAIL bubbles_done got=%0d exp=4", bus.done_cnt); end
    checks++; if (dut_issues !== 4) begin errors++; $display("FAIL bubbles_issues got=%0d exp=4", dut_issues); end
    drive(C_ACK, 1'b0, 16'd0, 8'd0);
  endtask

  task automatic test_zero_paths();
    dut_issues = 0;
    drive(C_RUN, 1'b1, 16'd9, 8'd0);
    checks++; if (bus.status !== 4'd3) begin errors++; $display("FAIL zero_status got=%0d exp=3", bus.status); end
    for (int i = 0; i < 3; i++) drive(C_NOP, 1'b1, 16'd9, 8'd0);
    checks++; if (bus.acc_out !== '0) begin errors++; $display("FAIL zero_acc got=%0d exp=0", bus.acc_out); end
    checks++; if (dut_issues !== 0) begin errors++; $display("FAIL zero_issues got=%0d exp=0", dut_issues); end
    drive(C_ACK, 1'b0, 16'd0, 8'd0);
  endtask

  task automatic test_abort();
    drive(C_RUN, 1'b1, 16'd1, 8'd10);
    for (int i = 0; i < 10; i++) drive(C_NOP, 1'b1, 16'd1, 8'd0);
    checks++; if (bus.status !== 4'd2) begin errors++; $display("FAIL abort_drain got=%0d exp=2", bus.status); end
    drive(C_NOP, 1'b1, 16'd1, 8'd0);
    drive(C_NOP, 1'b1, 16'd1, 8'd0);
    drive(C_ABORT, 1'b1, 16'd1, 8'd0);
    checks++; if (bus.status !== 4'd0 || bus.acc_out !== '0 || bus.done_cnt !== '0)
      begin errors++; $display("FAIL abort_idle status=%0d acc=%0d done=%0d exp=0/0/0", bus.status, bus.acc_out, bus.done_cnt); end
    drive(C_RUN, 1'b1, 16'd1, 8'd2);
    for (int k = 0; k < 20 && bus.status !== 4'd3; k++) drive(C_NOP, 1'b1, 16'd1, 8'd0);
    checks++; if (bus.status !== 4'd3) begin errors++; $display("FAIL rerun_complete got=%0d exp=3", bus.status); end
    checks++; if (bus.acc_out !== 24'd2) begin errors++; $display("FAIL rerun_acc got=%0d exp=2", bus.acc_out); end
    checks++; if (bus.done_cnt !== 8'd2) begin errors++; $display("FAIL rerun_done got=%0d exp=2", bus.done_cnt); end
    drive(C_ACK, 1'b0, 16'd0, 8'd0);
  endtask

  task automatic test_saturation();
    sbus.cmd = C_RUN; sbus.num_paths = 8'd2; sbus.rng_valid = 1'b1; sbus.res_din = 8'd200;
    @(negedge clk);
    sbus.cmd = C_NOP;
    for (int k = 0; k < 15 && sbus.status !== 4'd3; k++) @(negedge clk);
    checks++; if (sbus.status !== 4'd3) begin errors++; $display("FAIL sat_complete got=%0d exp=3", sbus.status); end
    checks++; if (sbus.acc_out !== SAT_ACC) begin errors++; $display("FAIL sat_acc got=%0d exp=%0d", sbus.acc_out, SAT_ACC); end
    checks++; if (sbus.overflow !== SAT_OVF) begin errors++; $display("FAIL sat_ovf got=%b exp=%b", sbus.overflow, SAT_OVF); end
    sbus.cmd = C_ACK; sbus.rng_valid = 1'b0;
    @(negedge clk);
    sbus.cmd = C_NOP;
    checks++; if (sbus.overflow !== 1'b0 || sbus.acc_out !== 8'd0)
      begin errors++; $display("FAIL sat_ack ovf=%b acc=%0d exp=0/0", sbus.overflow, sbus.acc_out); end
  endtask

  task automatic test_ignored_cmds();
    drive(C_RUN, 1'b1, 16'd3, 8'd1);
    for (int k = 0; k < 15 && bus.status !== 4'd3; k++) drive(C_NOP, 1'b1, 16'd3, 8'd0);
    drive(C_RUN, 1'b1, 16'd3, 8'd5);
    checks++; if (bus.status !== 4'd3 || bus.acc_out !== m_acc || bus.done_cnt !== 8'd1)
      begin errors++; $display("FAIL run_in_complete status=%0d acc=%0d done=%0d exp=3/%0d/1", bus.status, bus.acc_out, bus.done_cnt, m_acc); end
    drive(C_ACK, 1'b0, 16'd0, 8'd0);
    drive(C_RUN, 1'b0, 16'd0, 8'd20);
    drive(C_ACK, 1'b0, 16'd0, 8'd0);
    checks++; if (bus.status !== 4'd1) begin errors++; $display("FAIL ack_in_running got=%0d exp=1", bus.status); end
    drive(C_ABORT, 1'b0, 16'd0, 8'd0);
    drive(C_ABORT, 1'b0, 16'd0, 8'd0);
    checks++; if (bus.status !== 4'd0) begin errors++; $display("FAIL abort_in_idle got=%0d exp=0", bus.status); end
  endtask

  task automatic test_async_reset();
    drive(C_RUN, 1'b1, 16'd9, 8'd20);
    for (int i = 0; i < 7; i++) drive(C_NOP, 1'b1, 16'd9, 8'd0);
    checks++; if (bus.acc_out !== m_acc) begin errors++; $display("FAIL pre_reset_acc got=%0d exp=%0d", bus.acc_out, m_acc); end
    #2;
    nreset = 1'b0;
    #1;
    checks++; if (bus.status !== 4'd0 || bus.issue !== 1'b0 || bus.acc_out !== '0 || bus.done_cnt !== '0)
      begin errors++; $display("FAIL midrun_reset status=%0d issue=%b acc=%0d done=%0d exp=0/0/0/0", bus.status, bus.issue, bus.acc_out, bus.done_cnt); end
    m_st = S_IDLE; model_clear();
    @(negedge clk);
    nreset = 1'b1;
    drive(C_NOP, 1'b1, 16'd9, 8'd0);
    checks++; if (bus.status !== 4'd0) begin errors++; $display("FAIL post_reset_status got=%0d exp=0", bus.status); end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_bubbles();
    test_zero_paths();
    test_abort();
    test_saturation();
    test_ignored_cmds();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
